hazard_sched: RTL and testbench

- Pipeline hazard scheduler for the 5-stage MIPS core.
- Computes the operand-forwarding selects for EXE and ID, and the load-use stall.
- Handles branch/jump flushes.
- Sequences the multi-cycle HI/LO multiply/divide unit: tracks its busy state, stalls the front end on conflicts, and issues the final HI/LO write pulse.
- Sits beside the ID/EXE/MEM/WB pipe registers and drives their enable/flush controls.

---
 rtl/pipeline_types_pkg.sv | 24 ++
 rtl/hazard_sched_md_seq.sv | 59 +++++
 rtl/hazard_sched.sv | 111 +++++++++++
 tb/tb_hazard_sched.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_types_pkg.sv
// Shared types for the 5-stage pipeline hazard scheduler: forwarding selects,
// multiply/divide sequencer states and the load writeback encoding.
package pipeline_types_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  localparam logic [1:0] DM2REG_LOAD = 2'b01;

  // A producer hits a reader only if it writes a real register (not $0) of the same index.
  function automatic logic reg_hit(input logic we, input logic [4:0] wa, input logic [4:0] ra);
    return we && (wa != 5'd0) && (wa == ra);
  endfunction

endpackage

// File: rtl/hazard_sched_md_seq.sv
// Multiply/divide sequencer: tracks the HI/LO unit busy window with a
// down-counter and emits the one-cycle HI/LO commit pulse.
//
// state | meaning
// IDLE  | unit free, a non-stalled mult/div in ID is accepted
// BUSY  | operation in flight, counter runs down to 0
// DONE  | hilo_we asserted for one cycle, then back to IDLE
module md_seq
  import pipeline_types_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic div,
  input  logic stall,
  output logic md_busy,
  output logic hilo_we
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_DONE = DONE;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !stall) begin
            state <= ST_BUSY;
            cnt   <= div ? DIV_LOAD : MUL_LOAD;
          end
        end
        ST_BUSY: begin
          if (cnt == '0) state <= ST_DONE;
          else           cnt   <= cnt - 1'b1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign md_busy = (state != ST_IDLE);
  assign hilo_we = (state == ST_DONE);

endmodule

// File: rtl/hazard_sched.sv
// Hazard scheduler for the 5-stage MIPS core: forwarding selects, load-use,
// branch and HI/LO stalls, redirect flush. HAZARD_PERF_EN adds stall/flush counters.
module hazard_sched
  import pipeline_types_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       use_rs_id,
  input  logic       use_rt_id,
  input  logic       branch_id,
  input  logic       take_id,
  input  logic       hilo_rd_id,
  input  logic       md_start_id,
  input  logic       md_div_id,
  input  logic [4:0] rs_ex,
  input  logic [4:0] rt_ex,
  input  logic [4:0] rf_wa_ex,
  input  logic       we_reg_ex,
  input  logic [1:0] dm2reg_ex,
  input  logic [4:0] rf_wa_mem,
  input  logic       we_reg_mem,
  input  logic [1:0] dm2reg_mem,
  input  logic [4:0] rf_wa_wb,
  input  logic       we_reg_wb,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic       flush_e,
  output logic [1:0] fwd_a_e,
  output logic [1:0] fwd_b_e,
  output logic       fwd_a_d,
  output logic       fwd_b_d,
  output logic       md_busy,
  output logic       hilo_we
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  logic lu, bs, ms, stall;
  logic ex_load, mem_load;

  function automatic logic [1:0] fwd_e(input logic [4:0] src);
    if (reg_hit(we_reg_mem, rf_wa_mem, src))     return FWD_MEM;
    else if (reg_hit(we_reg_wb, rf_wa_wb, src))  return FWD_WB;
    else                                         return FWD_RF;
  endfunction

  always_comb begin
    fwd_a_e = fwd_e(rs_ex);
    fwd_b_e = fwd_e(rt_ex);
  end

  assign fwd_a_d = branch_id && reg_hit(we_reg_mem, rf_wa_mem, rs_id);
  assign fwd_b_d = branch_id && reg_hit(we_reg_mem, rf_wa_mem, rt_id);

  assign ex_load  = (dm2reg_ex == DM2REG_LOAD);
  assign mem_load = (dm2reg_mem == DM2REG_LOAD);

  assign lu = ex_load && ((use_rs_id && reg_hit(we_reg_ex, rf_wa_ex, rs_id)) ||
                          (use_rt_id && reg_hit(we_reg_ex, rf_wa_ex, rt_id)));

  // Branches compare in ID, so they wait on any EXE result and on loads still in MEM.
  assign bs = branch_id && (reg_hit(we_reg_ex, rf_wa_ex, rs_id)  ||
                            reg_hit(we_reg_ex, rf_wa_ex, rt_id)  ||
                            reg_hit(mem_load, rf_wa_mem, rs_id)  ||
                            reg_hit(mem_load, rf_wa_mem, rt_id));

  assign ms    = md_busy && (hilo_rd_id || md_start_id);
  assign stall = lu | bs | ms;

  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_e = stall;
  assign flush_d = take_id && !stall;

  md_seq #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (md_start_id),
    .div     (md_div_id),
    .stall   (stall),
    .md_busy (md_busy),
    .hilo_we (hilo_we)
  );

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))   stall_cnt <= stall_cnt + 1'b1;
      if (flush_d && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Randomized + directed bench for hazard_sched against a cycle-indexed reference model.
`timescale 1ns/1ps
module tb_hazard_sched;

  localparam int MUL_N = 4;
  localparam int DIV_N = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_id, rt_id, rs_ex, rt_ex, rf_wa_ex, rf_wa_mem, rf_wa_wb;
  logic       use_rs_id, use_rt_id, branch_id, take_id, hilo_rd_id, md_start_id, md_div_id;
  logic       we_reg_ex, we_reg_mem, we_reg_wb;
  logic [1:0] dm2reg_ex, dm2reg_mem;
  logic       stall_f, stall_d, flush_d, flush_e, fwd_a_d, fwd_b_d, md_busy, hilo_we;
  logic [1:0] fwd_a_e, fwd_b_e;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: cycle index and the cycle on which the HI/LO commit is due.
  int cyc = 0;
  int hilo_cyc = -1;
  int m_stall_cnt = 0;
  int m_flush_cnt = 0;

  always #5 clk = ~clk;

  hazard_sched #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_id(rs_id), .rt_id(rt_id), .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
    .branch_id(branch_id), .take_id(take_id), .hilo_rd_id(hilo_rd_id),
    .md_start_id(md_start_id), .md_div_id(md_div_id),
    .rs_ex(rs_ex), .rt_ex(rt_ex), .rf_wa_ex(rf_wa_ex), .we_reg_ex(we_reg_ex), .dm2reg_ex(dm2reg_ex),
    .rf_wa_mem(rf_wa_mem), .we_reg_mem(we_reg_mem), .dm2reg_mem(dm2reg_mem),
    .rf_wa_wb(rf_wa_wb), .we_reg_wb(we_reg_wb),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
    .md_busy(md_busy), .hilo_we(hilo_we)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic bit m_busy();
    return (hilo_cyc >= 0) && (cyc <= hilo_cyc);
  endfunction

  function automatic int m_fwd_e(input int src);
    if (src != 0 && we_reg_mem && src == int'(rf_wa_mem)) return 2;
    if (src != 0 && we_reg_wb  && src == int'(rf_wa_wb))  return 1;
    return 0;
  endfunction

  function automatic bit m_fwd_d(input int src);
    return branch_id && src != 0 && we_reg_mem && src == int'(rf_wa_mem);
  endfunction

  function automatic bit m_stall();
    bit hz = 0;
    int ex_w  = int'(rf_wa_ex);
    int mem_w = int'(rf_wa_mem);
    if (dm2reg_ex == 2'b01 && we_reg_ex && ex_w != 0)
      if ((use_rs_id && int'(rs_id) == ex_w) || (use_rt_id && int'(rt_id) == ex_w)) hz = 1;
    if (branch_id) begin
      if (we_reg_ex && ex_w != 0 && (int'(rs_id) == ex_w || int'(rt_id) == ex_w)) hz = 1;
      if (dm2reg_mem == 2'b01 && mem_w != 0 && (int'(rs_id) == mem_w || int'(rt_id) == mem_w)) hz = 1;
    end
    if (m_busy() && (hilo_rd_id || md_start_id)) hz = 1;
    return hz;
  endfunction

  task automatic idle_inputs();
    {rs_id, rt_id, rs_ex, rt_ex, rf_wa_ex, rf_wa_mem, rf_wa_wb} = '0;
    {use_rs_id, use_rt_id, branch_id, take_id, hilo_rd_id, md_start_id, md_div_id} = '0;
    {we_reg_ex, we_reg_mem, we_reg_wb} = '0;
    dm2reg_ex = 2'b00;
    dm2reg_mem = 2'b00;
  endtask

  task automatic model_reset();
    hilo_cyc = -1;
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  // Check one cycle at the falling edge, then advance the model across the rising edge.
  task automatic step();
    bit st;
    bit fl;
    @(negedge clk);
    st = m_stall();
    fl = take_id && !st;
    chk("stall_f", 32'(stall_f), 32'(st));
    chk("stall_d", 32'(stall_d), 32'(st));
    chk("flush_e", 32'(flush_e), 32'(st));
    chk("flush_d", 32'(flush_d), 32'(fl));
    chk("fwd_a_e", 32'(fwd_a_e), 32'(m_fwd_e(int'(rs_ex))));
    chk("fwd_b_e", 32'(fwd_b_e), 32'(m_fwd_e(int'(rt_ex))));
    chk("fwd_a_d", 32'(fwd_a_d), 32'(m_fwd_d(int'(rs_id))));
    chk("fwd_b_d", 32'(fwd_b_d), 32'(m_fwd_d(int'(rt_id))));
    chk("md_busy", 32'(md_busy), 32'(m_busy()));
    chk("hilo_we", 32'(hilo_we), 32'(cyc == hilo_cyc));
`ifdef HAZARD_PERF_EN
    chk("stall_cnt", stall_cnt, 32'(m_stall_cnt));
    chk("flush_cnt", flush_cnt, 32'(m_flush_cnt));
`endif
    @(posedge clk);
    if (md_start_id && !st && !m_busy())
      hilo_cyc = cyc + (md_div_id ? DIV_N : MUL_N) + 1;
    if (st) m_stall_cnt++;
    if (fl) m_flush_cnt++;
    cyc++;
    #1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #3;
    chk("rst_md_busy", 32'(md_busy), 32'd0);
    chk("rst_hilo_we", 32'(hilo_we), 32'd0);
    chk("rst_stall", 32'(stall_d), 32'd0);
    chk("rst_fwd_a_e", 32'(fwd_a_e), 32'd0);
    #4 rst_n = 1'b1;

    // Load-use: lw $8 in EXE, consumer of $8 in ID, then load forwarded from MEM.
    idle_inputs();
    rf_wa_ex = 5'd8; we_reg_ex = 1'b1; dm2reg_ex = 2'b01; rs_id = 5'd8; use_rs_id = 1'b1;
    #1 chk("lu_stall", 32'(stall_f), 32'd1);
    step();
    idle_inputs();
    rf_wa_mem = 5'd8; we_reg_mem = 1'b1; dm2reg_mem = 2'b01; rs_ex = 5'd8;
    #1 chk("lu_fwd_mem", 32'(fwd_a_e), 32'd2);
    step();

    // MEM over WB, WB alone, and $0 never forwards.
    idle_inputs();
    rf_wa_mem = 5'd5; we_reg_mem = 1'b1; rf_wa_wb = 5'd5; we_reg_wb = 1'b1; rs_ex = 5'd5;
    step();
    we_reg_mem = 1'b0;
    #1 chk("fwd_wb", 32'(fwd_a_e), 32'd1);
    step();
    we_reg_mem = 1'b1; rf_wa_mem = 5'd0; rf_wa_wb = 5'd0; rs_ex = 5'd0;
    step();

    // Branch waits on EXE ALU result, then redirects with MEM forwarding.
    idle_inputs();
    branch_id = 1'b1; take_id = 1'b1; rs_id = 5'd3; rf_wa_ex = 5'd3; we_reg_ex = 1'b1;
    #1 chk("bs_no_flush", 32'(flush_d), 32'd0);
    step();
    rf_wa_ex = 5'd0; we_reg_ex = 1'b0; rf_wa_mem = 5'd3; we_reg_mem = 1'b1;
    #1 chk("bs_flush", 32'(flush_d), 32'd1);
    step();

    // mult then mflo held until the cycle after the commit pulse.
    idle_inputs();
    md_start_id = 1'b1;
    step();
    idle_inputs();
    hilo_rd_id = 1'b1;
    for (int i = 0; i < MUL_N + 3; i++) step();

    // load-use and HI/LO conflict together: still just one stall.
    idle_inputs();
    md_start_id = 1'b1;
    step();
    idle_inputs();
    hilo_rd_id = 1'b1; rf_wa_ex = 5'd2; we_reg_ex = 1'b1; dm2reg_ex = 2'b01; rt_id = 5'd2; use_rt_id = 1'b1;
    step();
    idle_inputs();
    for (int i = 0; i < MUL_N + 2; i++) step();

    // div aborted by reset mid-flight: no commit ever appears.
    md_start_id = 1'b1; md_div_id = 1'b1;
    step();
    idle_inputs();
    for (int i = 0; i < 9; i++) step();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort_busy", 32'(md_busy), 32'd0);
    chk("abort_hilo_we", 32'(hilo_we), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < DIV_N + 6; i++) step();

    // Randomized traffic over a small register window to provoke collisions.
    for (int i = 0; i < 1500; i++) begin
      rs_id = 5'($urandom_range(0, 3));      rt_id = 5'($urandom_range(0, 3));
      rs_ex = 5'($urandom_range(0, 3));      rt_ex = 5'($urandom_range(0, 3));
      rf_wa_ex = 5'($urandom_range(0, 3));   rf_wa_mem = 5'($urandom_range(0, 3));
      rf_wa_wb = 5'($urandom_range(0, 3));
      use_rs_id = 1'($urandom);  use_rt_id = 1'($urandom);
      branch_id = ($urandom_range(0, 3) == 0);
      take_id   = ($urandom_range(0, 3) == 0);
      hilo_rd_id = ($urandom_range(0, 5) == 0);
      md_start_id = ($urandom_range(0, 9) == 0);
      md_div_id = ($urandom_range(0, 3) == 0);
      we_reg_ex = 1'($urandom); we_reg_mem = 1'($urandom); we_reg_wb = 1'($urandom);
      dm2reg_ex = 2'($urandom); dm2reg_mem = 2'($urandom);
      step();
    end

    idle_inputs();
    for (int i = 0; i < DIV_N + 4; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
